word_loader: RTL

- Upstream stage of the vocabulary matcher.
- Accepts a byte stream over a valid/ready handshake and splits it into words on a delimiter.
- Writes each word, null-terminated, into the input-word SRAM, then pulses the matcher start and waits for its done/equal result.
- Presents one result record per word downstream over a valid/ready handshake.

---
 rtl/word_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/word_loader.sv
// word_loader: splits a delimiter-separated byte stream into words, writes each
// word null-terminated into the word SRAM, starts the matcher and forwards one
// result record per word.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready input byte stream (valid/ready)
//   wr_en/wr_addr/wr_data             word SRAM write port (registered)
//   match_start                       one-cycle matcher start pulse
//   match_done/match_equal            matcher completion and hit flag
//   res_valid/res_ready               result record handshake
//   res_hit/res_trunc/res_index       result record payload
module word_loader #(
  parameter int unsigned              ADDR_WIDTH = 4,
  parameter int unsigned              DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]    DELIM      = 8'h20,
  parameter int unsigned              CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  match_start,
  input  logic                  match_done,
  input  logic                  match_equal,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_hit,
  output logic                  res_trunc,
  output logic [CNT_WIDTH-1:0]  res_index
);

  // Last SRAM address is reserved for the terminating null.
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_TERM,
    S_START,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] ptr, ptr_d;
  logic                  trunc, trunc_d;
  logic [CNT_WIDTH-1:0]  idx, idx_d;
  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic                  match_start_d;
  logic                  res_valid_d, res_hit_d, res_trunc_d;
  logic [CNT_WIDTH-1:0]  res_index_d;
  logic                  accept;
  logic                  is_delim;

  // Ready depends on state only; held low while reset is asserted.
  assign in_ready = rst_n && ((state == S_IDLE) || (state == S_FILL));
  assign accept   = in_valid && in_ready;
  assign is_delim = (in_data == DELIM);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      trunc       <= 1'b0;
      idx         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      match_start <= 1'b0;
      res_valid   <= 1'b0;
      res_hit     <= 1'b0;
      res_trunc   <= 1'b0;
      res_index   <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      trunc       <= trunc_d;
      idx         <= idx_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      match_start <= match_start_d;
      res_valid   <= res_valid_d;
      res_hit     <= res_hit_d;
      res_trunc   <= res_trunc_d;
      res_index   <= res_index_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    trunc_d       = trunc;
    idx_d         = idx;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    match_start_d = 1'b0;
    res_valid_d   = res_valid;
    res_hit_d     = res_hit;
    res_trunc_d   = res_trunc;
    res_index_d   = res_index;

    unique case (state)
      S_IDLE: begin
        // Leading and repeated delimiters are swallowed here.
        if (accept && !is_delim) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = in_data;
          ptr_d     = ADDR_WIDTH'(1);
          state_d   = in_last ? S_TERM : S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          if (is_delim) begin
            state_d = S_TERM;
          end else if (ptr != PTR_LAST) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr;
            wr_data_d = in_data;
            ptr_d     = ptr + ADDR_WIDTH'(1);
          end else begin
            trunc_d = 1'b1;
          end
          if (in_last) begin
            state_d = S_TERM;
          end
        end
      end
      S_TERM: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr;
        wr_data_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        match_start_d = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (match_done) begin
          res_valid_d = 1'b1;
          res_hit_d   = match_equal && !trunc;
          res_trunc_d = trunc;
          res_index_d = idx;
          state_d     = S_REPORT;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          idx_d       = idx + CNT_WIDTH'(1);
          ptr_d       = '0;
          trunc_d     = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
